// File: rtl/wm_32.sv
`default_nettype none
// ============================================================================
//  Module   : wm_32
//  Purpose  : Unsigned 32x32 -> 64-bit Wallace-tree multiplier with a
//             two-stage free-running pipeline (tree | carry-propagate add).
//  Revision : 1.0 - initial release
// ============================================================================
module wm_32 (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [63:0] product
);

  localparam int c_rows   = 32;
  localparam int c_layers = 8;

  // Row storage for every reduction layer. Layer 0 holds the partial
  // products and layer 8 holds the final sum/carry pair in rows 0 and 1.
  logic [63:0] w_tree [0:c_layers][0:c_rows-1];
  logic [63:0] w_sum;
  logic [63:0] w_carry;
  logic [63:0] r_s1_sum;
  logic [63:0] r_s1_carry;

  // The 3:2 compressors work on whole 64-bit rows. Columns where one input
  // is always zero collapse to half adders during synthesis.
  always_comb begin
    int n;
    for (int l = 0; l <= c_layers; l++) begin
      for (int r = 0; r < c_rows; r++) begin
        w_tree[l][r] = 64'b0;
      end
    end
    for (int r = 0; r < c_rows; r++) begin
      w_tree[0][r] = B[r] ? ({32'b0, A} << r) : 64'b0;
    end
    n = c_rows;
    for (int l = 0; l < c_layers; l++) begin
      for (int g = 0; g < n / 3; g++) begin
        w_tree[l+1][2*g]   = w_tree[l][3*g] ^ w_tree[l][3*g+1] ^ w_tree[l][3*g+2];
        w_tree[l+1][2*g+1] = ((w_tree[l][3*g]   & w_tree[l][3*g+1]) |
                              (w_tree[l][3*g]   & w_tree[l][3*g+2]) |
                              (w_tree[l][3*g+1] & w_tree[l][3*g+2])) << 1;
      end
      // Rows that do not fill a complete group of three pass straight down.
      for (int k = 0; k < n % 3; k++) begin
        w_tree[l+1][2*(n/3)+k] = w_tree[l][3*(n/3)+k];
      end
      n = 2 * (n / 3) + n % 3;
    end
  end

  assign w_sum   = w_tree[c_layers][0];
  assign w_carry = w_tree[c_layers][1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_sum   <= 64'b0;
      r_s1_carry <= 64'b0;
      product    <= 64'b0;
    end else begin
      r_s1_sum   <= w_sum;
      r_s1_carry <= w_carry;
      product    <= r_s1_sum + r_s1_carry;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wm_32.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wm_32
//  Purpose  : Scoreboard bench for wm_32; expected products are queued as
//             operands are driven and compared two edges later.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wm_32;

  logic        clk;
  logic        rst;
  logic [31:0] A;
  logic [31:0] B;
  logic [63:0] product;

  int n_checks;
  int n_pass;
  logic [63:0] exp_q [$];

  wm_32 u_dut (
    .clk     (clk),
    .rst     (rst),
    .A       (A),
    .B       (B),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%016h expected 0x%016h", tag, act, exp);
  endtask

  // Drive one operand pair, advance one edge, then compare the oldest
  // queued result once it has had two edges to emerge.
  task automatic cycle(input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [63:0] e;
    A = a;
    B = b;
    exp_q.push_back({32'b0, a} * {32'b0, b});
    @(posedge clk);
    #1;
    if (exp_q.size() >= 2) begin
      e = exp_q.pop_front();
      chk(tag, product, e);
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1;
    A   = 32'd0;
    B   = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", product, 64'd0);
    rst = 1'b0;
    // Stage-1 registers start cleared, so the first edge after release yields 0.
    exp_q.push_back(64'd0);

    repeat (3) cycle(32'd0, 32'd0, "zero_hold");

    cycle(32'd3,    32'd7,   "3x7");
    cycle(32'd13,   32'd12,  "13x12");
    cycle(32'd3123, 32'd732, "3123x732");
    cycle(32'd13,   32'd337, "13x337");
    cycle(32'd99999, 32'd999999, "large1");
    cycle(32'd2147483643, 32'd2147483643, "large2");
    cycle(32'hFFFF_FFFF, 32'hFFFF_FFFF, "max_x_max");
    cycle(32'hFFFF_FFFF, 32'd1, "max_x_1");
    cycle(32'd0, 32'hFFFF_FFFF, "0_x_max");
    cycle(32'h8000_0000, 32'd2, "msb_x_2");
    repeat (4) cycle(32'hDEAD_BEEF, 32'h1234_5678, "const_hold");

    // Known values from the bench's own table, independent of the model.
    begin
      logic [63:0] lit [0:5];
      lit[0] = 64'd21;
      lit[1] = 64'd156;
      lit[2] = 64'd2286036;
      lit[3] = 64'd4381;
      lit[4] = 64'd99998900001;
      lit[5] = 64'd4611685996952551449;
      chk("lit_3x7",      {32'b0, 32'd3} * {32'b0, 32'd7}, lit[0]);
      chk("lit_large2",   {32'b0, 32'd2147483643} * {32'b0, 32'd2147483643}, lit[5]);
      chk("lit_large1",   {32'b0, 32'd99999} * {32'b0, 32'd999999}, lit[4]);
      chk("lit_3123x732", {32'b0, 32'd3123} * {32'b0, 32'd732}, lit[2]);
      chk("lit_13x12",    {32'b0, 32'd13} * {32'b0, 32'd12}, lit[1]);
      chk("lit_13x337",   {32'b0, 32'd13} * {32'b0, 32'd337}, lit[3]);
    end

    for (int i = 0; i < 1000; i++) cycle($urandom, $urandom, "random");

    // Reset between edges with data in flight.
    for (int i = 0; i < 5; i++) cycle($urandom, $urandom, "pre_rst");
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async", product, 64'd0);
    exp_q.delete();
    for (int i = 0; i < 2; i++) begin
      A = $urandom;
      B = $urandom;
      @(posedge clk);
      #1;
      chk("rst_held", product, 64'd0);
    end
    rst = 1'b0;
    exp_q.push_back(64'd0);
    for (int i = 0; i < 20; i++) cycle($urandom, $urandom, "post_rst");

    // Flush the two results still in the pipe.
    cycle(32'd0, 32'd0, "flush");
    cycle(32'd0, 32'd0, "flush");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
